// File: rtl/led_frame_regs_if.sv
// Memory bus bundle between the CPU-side master and the LED frame register block.
// Ports: mem_valid/mem_addr/mem_wdata/mem_wstrb driven by the master (wstrb = 0 means read),
//        mem_ready/mem_rdata returned by the slave (rdata valid while ready is high).
interface led_frame_regs_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/led_frame_regs.sv
// Purpose: double-buffered LED column frame buffer; CPU writes BACK, front copies at frame ticks.
// Latency: bus ack one cycle after a request is first seen; leds change the cycle after frame_tick.
// Backpressure: one-shot ack per request, a held request is re-acked only after an IDLE cycle.
// Ports: clk, reset (sync, active high); bus (slave modport: mem_valid/addr/wdata/wstrb in,
//        mem_ready/rdata out); leds1..leds4 front buffer bytes 0..3; frame_tick (counter all ones).
// Optional feature: define LED_BLINK_EN to add the BLINK register (offset 0x8) and column blinking.
module led_frame_regs #(
  parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
  parameter int          FRAME_BITS = 18
) (
  input  logic             clk,
  input  logic             reset,
  led_frame_regs_if.slave  bus,
  output logic [7:0]       leds1,
  output logic [7:0]       leds2,
  output logic [7:0]       leds3,
  output logic [7:0]       leds4,
  output logic             frame_tick
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  logic [0:0]            r_state;
  logic [FRAME_BITS-1:0] r_frame_cnt;
  logic [31:0]           r_back;
  logic [31:0]           r_front;
  logic [31:0]           r_rdata;
  logic                  r_pending;
  logic                  r_auto;

  logic [1:0]  w_off;
  logic        w_sel;
  logic        w_commit;
  logic        w_tick;
  logic        w_swap;
  logic [31:0] w_rd_val;
  logic        w_unused;

  // Byte lane bits never affect decode; this keeps them visibly consumed.
  assign w_unused = ^bus.mem_addr[1:0];

  assign w_off    = bus.mem_addr[3:2];
  // Offset 0xC is left to another slave, so it is never selected.
  assign w_sel    = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]) && (w_off != 2'b11);
  assign w_commit = (r_state == S_IDLE) && w_sel;

  assign w_tick     = &r_frame_cnt;
  assign frame_tick = w_tick;
  assign w_swap     = w_tick && (r_pending || r_auto);

  assign bus.mem_ready = (r_state == S_ACK);
  assign bus.mem_rdata = r_rdata;

  // Bus FSM: the ACK state always returns to IDLE, so a held request sees one idle gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= w_sel ? S_ACK : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + FRAME_BITS'(1);
    end
  end

`ifdef LED_BLINK_EN
  logic [7:0] r_blink_period;
  logic [7:0] r_blink_cnt;
  logic [3:0] r_blink_mask;
  logic [3:0] r_blank;
  logic       r_phase_off;

  logic       w_period_wr;
  logic       w_mask_wr;
  logic [7:0] w_cnt_nxt;
  logic       w_phase_nxt;

  assign w_period_wr = w_commit && (w_off == 2'd2) && bus.mem_wstrb[0];
  assign w_mask_wr   = w_commit && (w_off == 2'd2) && bus.mem_wstrb[1];

  // A PERIOD write restarts the blink cycle and wins over a coincident tick.
  always_comb begin
    w_cnt_nxt   = r_blink_cnt;
    w_phase_nxt = r_phase_off;
    if (w_period_wr) begin
      w_cnt_nxt   = 8'd0;
      w_phase_nxt = 1'b0;
    end else if (w_tick) begin
      if (r_blink_period == 8'd0) begin
        w_cnt_nxt   = 8'd0;
        w_phase_nxt = 1'b0;
      end else if (r_blink_cnt == r_blink_period - 8'd1) begin
        w_cnt_nxt   = 8'd0;
        w_phase_nxt = ~r_phase_off;
      end else begin
        w_cnt_nxt   = r_blink_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_period <= '0;
      r_blink_cnt    <= '0;
      r_blink_mask   <= '0;
      r_blank        <= '0;
      r_phase_off    <= 1'b0;
    end else begin
      r_blink_cnt <= w_cnt_nxt;
      r_phase_off <= w_phase_nxt;
      if (w_period_wr) r_blink_period <= bus.mem_wdata[7:0];
      if (w_mask_wr)   r_blink_mask   <= bus.mem_wdata[11:8];
      // Blanking only moves on frame boundaries so columns never change mid-scan.
      if (w_tick)      r_blank        <= w_phase_nxt ? r_blink_mask : 4'd0;
    end
  end

  assign leds1 = r_front[7:0]   & {8{~r_blank[0]}};
  assign leds2 = r_front[15:8]  & {8{~r_blank[1]}};
  assign leds3 = r_front[23:16] & {8{~r_blank[2]}};
  assign leds4 = r_front[31:24] & {8{~r_blank[3]}};
`else
  assign leds1 = r_front[7:0];
  assign leds2 = r_front[15:8];
  assign leds3 = r_front[23:16];
  assign leds4 = r_front[31:24];
`endif

  // Read value reflects state before any write committing on the same edge.
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      2'd0:    w_rd_val = r_back;
      2'd1:    w_rd_val = {30'd0, r_auto, r_pending};
`ifdef LED_BLINK_EN
      2'd2:    w_rd_val = {20'd0, r_blink_mask, r_blink_period};
`endif
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_commit ? w_rd_val : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_back <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_commit && (w_off == 2'd0) && bus.mem_wstrb[i]) begin
          r_back[8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // Swap copies the pre-write BACK; a SWAP write on the tick edge re-arms pending
  // after the clear, so it is honoured on the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_front   <= '0;
      r_pending <= 1'b0;
      r_auto    <= 1'b0;
    end else begin
      if (w_swap) begin
        r_front   <= r_back;
        r_pending <= 1'b0;
      end
      if (w_commit && (w_off == 2'd1) && bus.mem_wstrb[0]) begin
        r_auto <= bus.mem_wdata[1];
        if (bus.mem_wdata[0]) r_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_regs.sv
module tb_led_frame_regs;
  localparam int          FB    = 5;
  localparam int          FRAME = 1 << FB;
  localparam logic [31:0] BASE  = 32'h0200_0000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] leds1, leds2, leds3, leds4;
  logic       frame_tick;

  led_frame_regs_if bus();

  led_frame_regs #(.BASE_ADDR(BASE), .FRAME_BITS(FB)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: registers as the CPU sees them, plus cycle count since reset.
  logic [31:0] m_back, m_front, m_rdata;
  logic        m_pending, m_auto, m_acked;
  int          m_cyc;
  logic [7:0]  m_period;
  logic [3:0]  m_mask, m_blank;
  int          m_frames;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic m_tick();
    return (m_cyc % FRAME) == FRAME - 1;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] off);
    case (off)
      2'd0:    return m_back;
      2'd1:    return {30'd0, m_auto, m_pending};
`ifdef LED_BLINK_EN
      2'd2:    return {20'd0, m_mask, m_period};
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_leds();
    logic [31:0] v;
    v = m_front;
    for (int k = 0; k < 4; k++) if (m_blank[k]) v[8*k +: 8] = 8'd0;
    return v;
  endfunction

  // One clock: predict the edge from the current inputs, then compare DUT outputs.
  task automatic cycle();
    logic [1:0]  off;
    logic        sel, commit, tick, swap;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          fr_n;
    off    = bus.mem_addr[3:2];
    wd     = bus.mem_wdata;
    ws     = bus.mem_wstrb;
    sel    = bus.mem_valid && (bus.mem_addr[31:4] == BASE[31:4]) && (off != 2'd3);
    commit = sel && !m_acked;
    tick   = m_tick();
    swap   = tick && (m_pending || m_auto);
    @(posedge clk);
    #1;
    if (reset) begin
      m_back = 0; m_front = 0; m_rdata = 0; m_pending = 0; m_auto = 0; m_acked = 0;
      m_cyc = 0; m_period = 0; m_mask = 0; m_blank = 0; m_frames = 0;
    end else begin
      m_rdata = commit ? m_read(off) : 32'd0;
      if (swap) begin
        m_front   = m_back;
        m_pending = 0;
      end
      if (commit && off == 2'd0)
        for (int i = 0; i < 4; i++) if (ws[i]) m_back[8*i +: 8] = wd[8*i +: 8];
      if (commit && off == 2'd1 && ws[0]) begin
        m_auto = wd[1];
        if (wd[0]) m_pending = 1;
      end
`ifdef LED_BLINK_EN
      // Phase after t frames since the last PERIOD write is off when floor(t/PERIOD) is odd.
      fr_n = (commit && off == 2'd2 && ws[0]) ? 0 : (tick ? m_frames + 1 : m_frames);
      if (tick) m_blank = (m_period != 0 && ((fr_n / m_period) % 2) == 1) ? m_mask : 4'd0;
      if (commit && off == 2'd2 && ws[0]) m_period = wd[7:0];
      if (commit && off == 2'd2 && ws[1]) m_mask   = wd[11:8];
      m_frames = fr_n;
`else
      fr_n = 0;
`endif
      m_acked = commit;
      m_cyc++;
    end
    chk_eq("mem_ready", {31'd0, bus.mem_ready}, {31'd0, m_acked});
    chk_eq("mem_rdata", bus.mem_rdata, m_rdata);
    chk_eq("leds", {leds4, leds3, leds2, leds1}, m_leds());
    chk_eq("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick()});
  endtask

  task automatic bus_idle();
    bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0;
  endtask

  task automatic bus_xfer(input logic [31:0] off, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rd);
    bus.mem_valid = 1; bus.mem_addr = BASE + off; bus.mem_wdata = data; bus.mem_wstrb = strb;
    cycle();
    rd = bus.mem_rdata;
    bus_idle();
    cycle();
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 2 * FRAME && !m_tick(); i++) cycle();
    chk_eq("tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  logic [31:0] rd, v;
  logic [3:0]  pat;
  int          sel_a;

  initial begin
    reset = 1;
    bus_idle();
    m_acked = 0; m_cyc = 0;
    repeat (3) cycle();
    reset = 0;

    // Reset values through the bus and on the outputs.
    bus_xfer(32'h0, 32'h0, 4'h0, rd);
    chk_eq("rd_back_rst", rd, 32'h0);
    bus_xfer(32'h4, 32'h0, 4'h0, rd);
    chk_eq("rd_ctrl_rst", rd, 32'h0);
    chk_eq("leds_rst", {leds4, leds3, leds2, leds1}, 32'h0);

    // Full-word write then SWAP: visible only after the tick edge.
    bus_xfer(32'h0, 32'hA55A_0FF0, 4'hF, rd);
    bus_xfer(32'h4, 32'h1, 4'h1, rd);
    chk_eq("leds_pre_swap", {leds4, leds3, leds2, leds1}, 32'h0);
    wait_tick();
    chk_eq("leds_on_tick", {leds4, leds3, leds2, leds1}, 32'h0);
    cycle();
    chk_eq("leds1_swap", {24'd0, leds1}, 32'hF0);
    chk_eq("leds2_swap", {24'd0, leds2}, 32'h0F);
    chk_eq("leds3_swap", {24'd0, leds3}, 32'h5A);
    chk_eq("leds4_swap", {24'd0, leds4}, 32'hA5);
    bus_xfer(32'h4, 32'h0, 4'h0, rd);
    chk_eq("ctrl_after_swap", rd, 32'h0);

    // Single byte-lane write.
    bus_xfer(32'h0, 32'hFFFF_FFFF, 4'hF, rd);
    bus_xfer(32'h0, 32'h0033_0000, 4'b0100, rd);
    bus_xfer(32'h0, 32'h0, 4'h0, rd);
    chk_eq("byte_strobe", rd, 32'hFF33_FFFF);

    // SWAP landing exactly on the tick edge defers to the next frame.
    wait_tick();
    bus_xfer(32'h4, 32'h1, 4'h1, rd);
    chk_eq("no_swap_same_tick", {leds4, leds3, leds2, leds1}, 32'hA55A_0FF0);
    bus_xfer(32'h4, 32'h0, 4'h0, rd);
    chk_eq("pending_between", rd, 32'h1);
    wait_tick();
    cycle();
    chk_eq("deferred_swap", {leds4, leds3, leds2, leds1}, 32'hFF33_FFFF);

    // AUTO mode: each frame picks up the latest BACK.
    bus_xfer(32'h4, 32'h2, 4'h1, rd);
    for (int f = 0; f < 3; f++) begin
      v = $urandom();
      bus_xfer(32'h0, v, 4'hF, rd);
      wait_tick();
      cycle();
      chk_eq("auto_follow", {leds4, leds3, leds2, leds1}, v);
    end
    bus_xfer(32'h4, 32'h0, 4'h1, rd);

    // Held request: ack, gap, ack.
    bus.mem_valid = 1; bus.mem_addr = BASE; bus.mem_wstrb = 0;
    pat[3] = bus.mem_ready;
    cycle(); pat[2] = bus.mem_ready;
    cycle(); pat[1] = bus.mem_ready;
    cycle(); pat[0] = bus.mem_ready;
    bus_idle();
    cycle();
    chk_eq("hold_pattern", {28'd0, pat}, 32'h5);

    // Offset 0xC and out-of-block addresses get no ack.
    bus_xfer(32'hC, 32'h0, 4'h0, rd);
    chk_eq("no_ack_0xC", rd, 32'h0);
    bus_xfer(32'h10, 32'hFFFF_FFFF, 4'hF, rd);
    bus_xfer(32'h0, 32'h0, 4'h0, rd);
    chk_eq("foreign_write_ignored", rd, m_back);

`ifdef LED_BLINK_EN
    bus_xfer(32'h0, 32'hFFFF_FFFF, 4'hF, rd);
    bus_xfer(32'h4, 32'h1, 4'h1, rd);
    wait_tick();
    cycle();
    bus_xfer(32'h8, 32'h0000_0102, 4'h3, rd);
    for (int f = 0; f < 4; f++) begin
      wait_tick();
      cycle();
      chk_eq("blink_leds1", {24'd0, leds1}, (f == 1 || f == 2) ? 32'h00 : 32'hFF);
      chk_eq("blink_others", {8'd0, leds4, leds3, leds2}, 32'hFF_FFFF);
    end
`else
    bus_xfer(32'h8, 32'hFFFF_FFFF, 4'hF, rd);
    bus_xfer(32'h8, 32'h0, 4'h0, rd);
    chk_eq("blink_reads_zero", rd, 32'h0);
`endif

    // Reset arriving with a request: no ack follows.
    bus.mem_valid = 1; bus.mem_addr = BASE; bus.mem_wstrb = 0;
    reset = 1;
    cycle();
    chk_eq("rst_drop_ack", {31'd0, bus.mem_ready}, 32'd0);
    reset = 0;
    bus_idle();
    cycle();

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 4) begin
        sel_a = $urandom_range(0, 5);
        bus.mem_valid = 1;
        bus.mem_addr  = (sel_a == 5) ? (BASE + 32'h40) : (BASE + 32'(sel_a % 4) * 4);
        bus.mem_addr[1:0] = 2'($urandom_range(0, 3));
        bus.mem_wdata = $urandom();
        if (sel_a == 1) bus.mem_wdata[0] = ($urandom_range(0, 3) == 0);
        if (sel_a == 2) bus.mem_wdata[7:0] = 8'($urandom_range(0, 3));
        bus.mem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end else begin
        bus_idle();
      end
      cycle();
    end
    reset = 0;
    bus_idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_frame_regs.md
# led_frame_regs

Memory-mapped LED frame buffer that sits directly upstream of the LED column scanner: the CPU writes four 8-bit column patterns into a back buffer over the native valid/ready memory bus, and the block presents a tear-free front buffer on `leds1`..`leds4` to the scanner. Back-to-front copies happen only at frame boundaries. Frame boundaries are derived from a free-running counter sized to one full 4-column scan period.

## Interface
- `BASE_ADDR`, 32'h0200_0000 — word-aligned base; block decodes `BASE_ADDR`..`BASE_ADDR+8`.
- `FRAME_BITS`, 18 — width of frame counter; one frame = 2^FRAME_BITS cycles.
- `clk` in 1 — system clock.
- `reset` in 1 — synchronous, active-high reset.
- `mem_valid` in 1 — bus request.
- `mem_addr` in 32 — byte address.
- `mem_wdata` in 32 — write data.
- `mem_wstrb` in 4 — byte write strobes; 0 = read.
- `mem_ready` out 1 — one-cycle acknowledge.
- `mem_rdata` out 32 — read data, valid while `mem_ready`=1.
- `leds1` out 8 — column 1 pattern (front buffer byte 0).
- `leds2` out 8 — column 2 pattern (byte 1).
- `leds3` out 8 — column 3 pattern (byte 2).
- `leds4` out 8 — column 4 pattern (byte 3).
- `frame_tick` out 1 — high for one cycle when frame counter = all ones.

## Operation
- Register map (word offsets): 0x0 BACK (bytes 0..3 = columns 1..4, byte-strobed, R/W); 0x4 CTRL: bit0 SWAP (write 1 sets pending; read returns pending), bit1 AUTO (R/W), other bits read 0; 0x8 BLINK (see Configuration).
- Selected = `mem_valid` and `mem_addr[31:4]` = `BASE_ADDR[31:4]` and `mem_addr[3:2]` ≠ 3. Offset 0xC and unselected addresses: no ack (another slave responds).
- Bus FSM: IDLE → ACK when selected; ACK → IDLE unconditionally. `mem_ready`=1 only in ACK. A request still held in the ACK cycle is not re-acknowledged; a held request is acknowledged again only after one IDLE cycle.
- Writes commit on the IDLE→ACK edge, per byte strobe. CTRL: strobe 0 gates bits 0–1. SWAP written 0 has no effect. `mem_rdata` is registered on that same edge; it is 0 outside ACK.
- Frame counter: FRAME_BITS bits, increments every cycle, wraps to 0.
- Swap: on the edge where `frame_tick`=1, if pending or AUTO, then front ← back and pending ← 0.
- Simultaneous events:
  - A SWAP write on the `frame_tick` edge sets pending and does not swap that frame.
  - A BACK write on the `frame_tick` edge: the swap copies the pre-write back value.
  - Pending already set plus a SWAP write on the tick edge: the swap occurs and pending ends 1.
- Reset: back, front, CTRL, pending, counter, FSM → 0/IDLE; `mem_ready`, `mem_rdata`, `leds1..4`, `frame_tick` all 0. Reset mid-transaction drops the ack.

## Timing
- Bus latency: ack in the cycle after the request is first seen (1 wait state), for both reads and writes.
- `leds1..4` are registers and change on the swap edge, i.e. the cycle after `frame_tick` is high.
- Worst case from a SWAP write to visible output is 2^FRAME_BITS cycles.
- `frame_tick` is combinational from the counter and first high 2^FRAME_BITS−1 cycles after reset release.

## Configuration
- `LED_BLINK_EN` defined:
  - BLINK register: bits[7:0] PERIOD in frames, bits[11:8] column mask; reset 0.
  - Blink counter increments on each `frame_tick`. On reaching PERIOD−1 it clears and toggles phase.
  - While phase=off, masked columns output 0. Masking is registered and updates only on `frame_tick` edges.
  - PERIOD=0 holds phase=on and the counter at 0.
  - A PERIOD write clears the counter and sets phase=on.
- Without the macro: offset 0x8 is acknowledged, reads 0, ignores writes; no blink logic is synthesized.

## Test plan
- Reset, then read 0x0/0x4 → `mem_rdata`=0, `leds1..4`=0, `mem_ready` pulses once per read.
- Write BACK=32'hA55A0FF0 with strobe 4'b1111, then SWAP → leds unchanged until `frame_tick`; next cycle `leds1`=F0, `leds2`=0F, `leds3`=5A, `leds4`=A5; CTRL reads 0.
- Write BACK byte 2 only (strobe 4'b0100, data 32'h00330000) over 32'hFFFFFFFF → readback 32'hFF33FFFF.
- SWAP write landing exactly on the `frame_tick` edge → no swap that frame; swap at the next tick; CTRL bit0 reads 1 in between.
- AUTO=1, BACK rewritten every frame → leds follow BACK once per frame. Hold `mem_valid` for 4 cycles → `mem_ready` pattern 0,1,0,1.
- `LED_BLINK_EN`: PERIOD=2, mask=4'b0001, front=FF..FF → `leds1` alternates FF / 00 every 2 frames; `leds2..4` stay FF.
